push_debounce: RTL and testbench

Conditions the raw push-button inputs before they reach the up/down counter stage. Each button gets:
- a 2-FF synchronizer
- a debounce filter
- a per-button press FSM with optional auto-repeat

Outputs per button are a clean active-low level, which drops directly into the counter's i_Push, plus single-cycle press and release strobes.

---
 rtl/push_debounce.sv | 178 +++++++++++++++++
 tb/tb_push_debounce.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/push_debounce.sv
// push_debounce: per-button synchronizer, debounce filter and press FSM
// with optional auto-repeat. Produces a clean active-low level plus
// single-cycle press / release strobes for each button.
module push_debounce #(
  parameter int NUM_BTN    = 2,
  parameter int DEB_CYCLES = 1000000,
  parameter int REP_DELAY  = 25000000,
  parameter int REP_PERIOD = 5000000
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic [NUM_BTN-1:0] i_Btn,
  input  logic               i_RepEn,
  output logic [NUM_BTN-1:0] o_Push,
  output logic [NUM_BTN-1:0] o_Press,
  output logic [NUM_BTN-1:0] o_Release
);

  // Repeat counter must cover the longer of the two repeat intervals.
  localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int DEB_W   = ($clog2(DEB_CYCLES) < 1) ? 1 : $clog2(DEB_CYCLES);
  localparam int REP_W   = ($clog2(REP_MAX) < 1) ? 1 : $clog2(REP_MAX);

  // Terminal counts: the counter is cleared when it sits on these values.
  localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEB_CYCLES - 1);
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REP_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REP_PERIOD - 1);
  localparam logic [DEB_W-1:0] DEB_ONE     = DEB_W'(1);
  localparam logic [REP_W-1:0] REP_ONE     = REP_W'(1);

  typedef enum logic [1:0] {
    ST_UP     = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      logic             r_sync1;
      logic             r_sync2;
      logic             r_push;
      logic [DEB_W-1:0] r_deb_cnt;
      logic             w_differ;
      logic             w_accept;
      logic             w_press_evt;
      logic             w_rel_evt;

      state_t           r_state;
      state_t           w_state_next;
      logic [REP_W-1:0] r_rep_cnt;
      logic [REP_W-1:0] w_rep_cnt_next;
      logic             r_press;
      logic             r_rel;
      logic             w_press_next;
      logic             w_rel_next;

      // Two-stage synchronizer; idles high (button released).
      always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
          r_sync1 <= 1'b1;
          r_sync2 <= 1'b1;
        end else begin
          r_sync1 <= i_Btn[gi];
          r_sync2 <= r_sync1;
        end
      end

      // A level change is accepted on the DEB_CYCLES-th consecutive
      // differing sample; this is the same edge the counter sits on its
      // terminal value while the sample still differs.
      assign w_differ    = (r_sync2 != r_push);
      assign w_accept    = w_differ && (r_deb_cnt == DEB_LAST);
      assign w_press_evt = w_accept && !r_sync2;
      assign w_rel_evt   = w_accept && r_sync2;

      // Debounce filter: any matching sample restarts the count.
      always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
          r_push    <= 1'b1;
          r_deb_cnt <= '0;
        end else if (!w_differ) begin
          r_deb_cnt <= '0;
        end else if (w_accept) begin
          r_push    <= r_sync2;
          r_deb_cnt <= '0;
        end else begin
          r_deb_cnt <= r_deb_cnt + DEB_ONE;
        end
      end

      // Press FSM state register, repeat counter and registered strobes.
      always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
          r_state   <= ST_UP;
          r_rep_cnt <= '0;
          r_press   <= 1'b0;
          r_rel     <= 1'b0;
        end else begin
          r_state   <= w_state_next;
          r_rep_cnt <= w_rep_cnt_next;
          r_press   <= w_press_next;
          r_rel     <= w_rel_next;
        end
      end

      // Next-state logic; an accepted release always wins.
      always_comb begin
        w_state_next = r_state;
        case (r_state)
          ST_UP: begin
            if (w_press_evt) w_state_next = ST_HOLD;
          end
          ST_HOLD: begin
            if (w_rel_evt) begin
              w_state_next = ST_UP;
            end else if (i_RepEn && (r_rep_cnt == DELAY_LAST)) begin
              w_state_next = ST_REPEAT;
            end
          end
          ST_REPEAT: begin
            if (w_rel_evt) begin
              w_state_next = ST_UP;
            end else if (!i_RepEn) begin
              w_state_next = ST_HOLD;
            end
          end
          default: w_state_next = ST_UP;
        endcase
      end

      // Output / counter logic: strobes and repeat counter for next edge.
      always_comb begin
        w_press_next   = 1'b0;
        w_rel_next     = 1'b0;
        w_rep_cnt_next = r_rep_cnt;
        case (r_state)
          ST_UP: begin
            w_rep_cnt_next = '0;
            if (w_press_evt) w_press_next = 1'b1;
          end
          ST_HOLD: begin
            if (w_rel_evt) begin
              w_rel_next     = 1'b1;
              w_rep_cnt_next = '0;
            end else if (!i_RepEn) begin
              w_rep_cnt_next = '0;
            end else if (r_rep_cnt == DELAY_LAST) begin
              w_press_next   = 1'b1;
              w_rep_cnt_next = '0;
            end else begin
              w_rep_cnt_next = r_rep_cnt + REP_ONE;
            end
          end
          ST_REPEAT: begin
            if (w_rel_evt) begin
              w_rel_next     = 1'b1;
              w_rep_cnt_next = '0;
            end else if (!i_RepEn) begin
              w_rep_cnt_next = '0;
            end else if (r_rep_cnt == PERIOD_LAST) begin
              w_press_next   = 1'b1;
              w_rep_cnt_next = '0;
            end else begin
              w_rep_cnt_next = r_rep_cnt + REP_ONE;
            end
          end
          default: w_rep_cnt_next = '0;
        endcase
      end

      assign o_Push[gi]    = r_push;
      assign o_Press[gi]   = r_press;
      assign o_Release[gi] = r_rel;
    end
  endgenerate

endmodule

// File: tb/tb_push_debounce.sv
// tb_push_debounce: directed scenarios plus randomized button activity,
// checked every cycle against a window/timestamp model of the button rules.
module tb_push_debounce;
  localparam int NB   = 2;
  localparam int DEB  = 4;
  localparam int RD   = 10;
  localparam int RP   = 3;
  localparam int HMAX = 16384;

  logic          i_Clk   = 1'b0;
  logic          i_Rst   = 1'b0;
  logic [NB-1:0] i_Btn   = 2'b11;
  logic          i_RepEn = 1'b0;
  logic [NB-1:0] o_Push;
  logic [NB-1:0] o_Press;
  logic [NB-1:0] o_Release;

  push_debounce #(
    .NUM_BTN(NB), .DEB_CYCLES(DEB), .REP_DELAY(RD), .REP_PERIOD(RP)
  ) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Btn(i_Btn), .i_RepEn(i_RepEn),
    .o_Push(o_Push), .o_Press(o_Press), .o_Release(o_Release)
  );

  always #5 i_Clk = ~i_Clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // raw_hist[b][n] is the pin value sampled at edge n since reset.
  // The filtered view of the pin at edge n is the raw sample from edge n-2.
  // A level is accepted when the last DEB filtered samples all oppose it.
  // Auto-repeat uses timestamps: a strobe is due RD (first) or RP (later)
  // edges after the last press / strobe / disabled edge.
  bit            raw_hist [NB][HMAX];
  logic [NB-1:0] m_push  = 2'b11;
  logic [NB-1:0] m_press = '0;
  logic [NB-1:0] m_rel   = '0;
  int            m_n     = 0;
  int            m_anchor [NB];
  bit            m_per    [NB];

  function automatic bit s_at(input int b, input int m);
    if (m < 2) return 1'b1;
    return raw_hist[b][m-2];
  endfunction

  always @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      m_push  = 2'b11;
      m_press = '0;
      m_rel   = '0;
      m_n     = 0;
      for (int b = 0; b < NB; b++) begin
        m_anchor[b] = 0;
        m_per[b]    = 0;
      end
    end else begin
      m_press = '0;
      m_rel   = '0;
      for (int b = 0; b < NB; b++) begin
        bit acc;
        raw_hist[b][m_n] = i_Btn[b];
        acc = 1'b1;
        for (int j = 0; j < DEB; j++)
          if (s_at(b, m_n - j) == m_push[b]) acc = 1'b0;
        if (acc) begin
          m_push[b] = ~m_push[b];
          if (m_push[b] == 1'b0) begin
            m_press[b]  = 1'b1;
            m_anchor[b] = m_n;
            m_per[b]    = 1'b0;
          end else begin
            m_rel[b] = 1'b1;
          end
        end else if (m_push[b] == 1'b0) begin
          if (!i_RepEn) begin
            m_anchor[b] = m_n;
            m_per[b]    = 1'b0;
          end else if (m_n - m_anchor[b] == (m_per[b] ? RP : RD)) begin
            m_press[b]  = 1'b1;
            m_anchor[b] = m_n;
            m_per[b]    = 1'b1;
          end
        end
      end
      m_n++;
    end
  end

  // Per-cycle comparison on the inactive edge.
  always @(negedge i_Clk) begin
    if (chk_en) begin
      check("cyc_push", 32'(o_Push), 32'(m_push));
      check("cyc_press", 32'(o_Press), 32'(m_press));
      check("cyc_release", 32'(o_Release), 32'(m_rel));
    end
  end

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  int          cnt;
  int          first;
  logic [31:0] mask;
  int          run_left [NB];

  initial begin
    #1 i_Rst = 1'b1;
    #2 chk_en = 1'b1;
    check("rst_push", 32'(o_Push), 32'h3);
    check("rst_press", 32'(o_Press), 32'h0);
    check("rst_release", 32'(o_Release), 32'h0);
    tick();
    tick();
    i_Rst = 1'b0;

    // 1. idle
    cnt = 0;
    repeat (20) begin
      tick();
      if (o_Press != 2'b00 || o_Release != 2'b00 || o_Push != 2'b11) cnt++;
    end
    check("idle_events", cnt, 0);
    $display("idle: 20 cycles, events=%0d", cnt);

    // 2. clean press with auto-repeat enabled (4)
    i_RepEn   = 1'b1;
    i_Btn[0]  = 1'b0;
    repeat (5) tick();
    check("press_before_latency", 32'(o_Push[0]), 32'h1);
    tick();
    check("press_push", 32'(o_Push[0]), 32'h0);
    check("press_strobe", 32'(o_Press[0]), 32'h1);
    mask = '0;
    for (int off = 1; off <= 30; off++) begin
      tick();
      if (o_Press[0]) mask[off] = 1'b1;
    end
    check("repeat_offsets", mask, 32'h1249_2400);
    $display("press btn0: repeat offset mask=%08h", mask);

    // 5. disable / re-enable repeat, then release
    i_RepEn = 1'b0;
    cnt = 0;
    repeat (15) begin
      tick();
      if (o_Press[0]) cnt++;
    end
    check("repeat_disabled", cnt, 0);
    i_RepEn = 1'b1;
    first = 0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (o_Press[0] && first == 0) first = t;
    end
    check("repeat_reenable_first", first, 10);
    i_Btn[0] = 1'b1;
    cnt = 0;
    repeat (8) begin
      tick();
      if (o_Release[0]) cnt++;
    end
    check("release_count", cnt, 1);
    check("release_push", 32'(o_Push[0]), 32'h1);
    $display("repeat gating: first re-enabled strobe at %0d, releases=%0d", first, cnt);

    // 3. bounce on button 1
    cnt = 0;
    for (int r = 0; r < 5; r++) begin
      i_Btn[1] = 1'b0;
      repeat (3) begin tick(); if (o_Press[1] || !o_Push[1]) cnt++; end
      i_Btn[1] = 1'b1;
      tick();
      if (o_Press[1] || !o_Push[1]) cnt++;
    end
    repeat (8) begin tick(); if (o_Press[1] || !o_Push[1]) cnt++; end
    check("bounce_rejected", cnt, 0);
    i_RepEn  = 1'b0;
    i_Btn[1] = 1'b0;
    cnt = 0;
    repeat (10) begin tick(); if (o_Press[1]) cnt++; end
    check("bounce_then_press", cnt, 1);
    i_Btn[1] = 1'b1;
    repeat (10) tick();
    $display("bounce btn1: single press count=%0d", cnt);

    // 6. async reset mid-REPEAT
    i_RepEn  = 1'b1;
    i_Btn[0] = 1'b0;
    repeat (17) tick();
    #2 i_Rst = 1'b1;
    #1;
    check("async_rst_push", 32'(o_Push), 32'h3);
    check("async_rst_press", 32'(o_Press), 32'h0);
    check("async_rst_release", 32'(o_Release), 32'h0);
    tick();
    tick();
    i_Rst = 1'b0;
    cnt = 0;
    repeat (5) begin tick(); if (o_Release[0]) cnt++; end
    check("rst_repress_wait", 32'(o_Push[0]), 32'h1);
    tick();
    check("rst_repress_push", 32'(o_Push[0]), 32'h0);
    check("rst_repress_strobe", 32'(o_Press[0]), 32'h1);
    check("rst_no_release", cnt, 0);
    $display("async reset: re-press accepted, releases=%0d", cnt);

    // randomized activity
    for (int b = 0; b < NB; b++) run_left[b] = 0;
    for (int it = 0; it < 3000; it++) begin
      tick();
      for (int b = 0; b < NB; b++) begin
        if (run_left[b] == 0) begin
          i_Btn[b]    = 1'($urandom_range(0, 1));
          run_left[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4))
                                                    : int'($urandom_range(4, 40));
        end else begin
          run_left[b]--;
        end
      end
      if ($urandom_range(0, 29) == 0) i_RepEn = ~i_RepEn;
      if (it == 1500) begin
        #2 i_Rst = 1'b1;
        #1;
        check("rand_rst_push", 32'(o_Push), 32'h3);
        check("rand_rst_strobes", 32'({o_Press, o_Release}), 32'h0);
        tick();
        i_Rst = 1'b0;
      end
    end
    i_Btn = 2'b11;
    repeat (12) tick();
    $display("random: 3000 cycles done, checks so far=%0d", n_checks);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
